// File: rtl/sram_bus_arbiter.sv
// Round-robin arbiter sharing one sram-like memory port between the fetch
// requester (read-only) and the data requester (load/store), one transaction at a time.
module sram_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT_INST, S_WAIT_DATA} state_t;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_grant;
    logic   r_pend;
    logic   r_pend_grant;
    logic   w_grant_valid;
    logic   w_grant;
    logic   w_pend_live;
    logic   w_hold;
    logic   w_handshake;

    // A stalled address phase keeps its grant while that requester still asks.
    assign w_pend_live = r_pend && ((r_pend_grant == GRANT_DATA) ? data_req : inst_req);
    assign w_hold      = (r_state == S_IDLE) && w_grant_valid && !mem_addr_ok;
    assign w_handshake = (r_state == S_IDLE) && w_grant_valid && mem_addr_ok;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = GRANT_INST;
        if (w_pend_live) begin
            w_grant_valid = 1'b1;
            w_grant       = r_pend_grant;
        end else if (inst_req && data_req) begin
            w_grant_valid = 1'b1;
            w_grant       = ~r_last_grant;
        end else if (inst_req) begin
            w_grant_valid = 1'b1;
            w_grant       = GRANT_INST;
        end else if (data_req) begin
            w_grant_valid = 1'b1;
            w_grant       = GRANT_DATA;
        end
    end

    // NOTE: non-blocking assignments for all state; the comb blocks read the old values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= GRANT_DATA;
            r_pend       <= 1'b0;
            r_pend_grant <= GRANT_INST;
        end else begin
            r_state <= w_next_state;
            r_pend  <= w_hold;
            if (w_hold) begin
                r_pend_grant <= w_grant;
            end
            if (w_handshake) begin
                r_last_grant <= w_grant;
            end
        end
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = 2'd0;
        mem_wstrb    = 4'h0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    mem_req = 1'b1;
                    if (w_grant == GRANT_DATA) begin
                        mem_wr       = data_wr;
                        mem_size     = data_size;
                        mem_wstrb    = data_wstrb;
                        mem_addr     = data_addr;
                        mem_wdata    = data_wdata;
                        data_addr_ok = mem_addr_ok;
                    end else begin
                        mem_size     = 2'd2;
                        mem_addr     = inst_addr;
                        inst_addr_ok = mem_addr_ok;
                    end
                    if (mem_addr_ok) begin
                        w_next_state = (w_grant == GRANT_DATA) ? S_WAIT_DATA : S_WAIT_INST;
                    end
                end
            end
            S_WAIT_INST: begin
                inst_data_ok = mem_data_ok;
                if (mem_data_ok) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_DATA: begin
                data_data_ok = mem_data_ok;
                if (mem_data_ok) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        // Handshakes are silenced while reset is held so nothing is accepted or completed.
        if (reset) begin
            mem_req      = 1'b0;
            inst_addr_ok = 1'b0;
            data_addr_ok = 1'b0;
            inst_data_ok = 1'b0;
            data_data_ok = 1'b0;
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scenario bench for sram_bus_arbiter: expected responses are queued at the
// address phase and matched by a monitor when a data_ok appears.
module tb_sram_bus_arbiter;
    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    sram_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic [4:0] hs;
    assign hs = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0f0f_0000;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd2;
        data_wstrb  = 4'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every data_ok must match the oldest queued expectation.
    always begin
        @(negedge clk);
        #2;
        if (inst_data_ok || data_data_ok) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: inst_data_ok=%b data_data_ok=%b with nothing outstanding",
                         inst_data_ok, data_data_ok);
            end else begin
                mon_e = exp_q.pop_front();
                if ({data_data_ok, inst_data_ok} !== (mon_e.is_data ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL sb_owner: data_ok {data,inst}=%b%b expected %b",
                             data_data_ok, inst_data_ok, mon_e.is_data ? 2'b10 : 2'b01);
                end
                checks++;
                if ((mon_e.is_data ? data_rdata : inst_rdata) !== mon_e.rdata) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h expected %h",
                             mon_e.is_data ? data_rdata : inst_rdata, mon_e.rdata);
                end
            end
        end
    end

    task automatic test_reset();
        reset       = 1'b1;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            checks++;
            if (hs !== 5'b00000) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: handshakes=%b expected 00000", i, hs);
            end
        end
        tick();
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_inst_only();
        tick();
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0000;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b11000) begin
            errors++;
            $display("FAIL inst_addr_phase: handshakes=%b expected 11000", hs);
        end
        checks++;
        if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== {1'b0, 2'd2, 4'h0, 32'h1c00_0000, 32'h0}) begin
            errors++;
            $display("FAIL inst_fields: wr=%b size=%0d wstrb=%h addr=%h wdata=%h expected 0/2/0/1c000000/0",
                     mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
        end
        exp_q.push_back('{is_data: 1'b0, rdata: 32'h0280_0c0c});
        tick();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++;
            $display("FAIL inst_wait: handshakes=%b expected 00000", hs);
        end
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0280_0c0c;
        #1;
        checks++;
        if (hs !== 5'b00010) begin
            errors++;
            $display("FAIL inst_data_phase: handshakes=%b expected 00010", hs);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_store();
        tick();
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_size   = 2'd0;
        data_wstrb  = 4'b0100;
        data_addr   = 32'h0000_0008;
        data_wdata  = 32'h00ab_0000;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b10100) begin
            errors++;
            $display("FAIL store_addr_phase: handshakes=%b expected 10100", hs);
        end
        checks++;
        if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 2'd0, 4'b0100, 32'h8, 32'h00ab_0000}) begin
            errors++;
            $display("FAIL store_fields: wr=%b size=%0d wstrb=%h addr=%h wdata=%h expected 1/0/4/00000008/00ab0000",
                     mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
        end
        exp_q.push_back('{is_data: 1'b1, rdata: 32'h1234_5678});
        tick();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1234_5678;
        #1;
        checks++;
        if (hs !== 5'b00001) begin
            errors++;
            $display("FAIL store_done: handshakes=%b expected 00001", hs);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_tie();
        logic [31:0] ia;
        logic [31:0] da;
        logic        owner;
        logic [31:0] oa;
        do_reset();
        ia = 32'h1c00_0100;
        da = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            owner = (t % 2 == 1);
            oa    = owner ? da : ia;
            tick();
            inst_req    = 1'b1;
            data_req    = 1'b1;
            inst_addr   = ia;
            data_addr   = da;
            mem_addr_ok = 1'b1;
            mem_data_ok = 1'b0;
            #1;
            checks++;
            if (hs !== (owner ? 5'b10100 : 5'b11000) || mem_addr !== oa) begin
                errors++;
                $display("FAIL tie_grant%0d: handshakes=%b addr=%h expected %b addr=%h",
                         t, hs, mem_addr, owner ? 5'b10100 : 5'b11000, oa);
            end
            exp_q.push_back('{is_data: owner, rdata: mem_model(oa)});
            tick();
            mem_data_ok = 1'b1;
            mem_rdata   = mem_model(oa);
            #1;
            checks++;
            if (hs !== (owner ? 5'b00001 : 5'b00010)) begin
                errors++;
                $display("FAIL tie_resp%0d: handshakes=%b expected %b",
                         t, hs, owner ? 5'b00001 : 5'b00010);
            end
            if (owner) da = da + 32'h4;
            else       ia = ia + 32'h4;
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [31:0] ia;
        logic [31:0] da;
        // An inst transaction first, so a plain tie would now favour data.
        tick();
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0200;
        mem_addr_ok = 1'b1;
        exp_q.push_back('{is_data: 1'b0, rdata: mem_model(32'h1c00_0200)});
        tick();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = mem_model(32'h1c00_0200);
        tick();
        clear_inputs();
        ia = 32'h1c00_0300;
        da = 32'h0000_0400;
        inst_addr = ia;
        data_addr = da;
        for (int c = 0; c < 3; c++) begin
            tick();
            inst_req    = 1'b1;
            data_req    = (c >= 1);
            mem_addr_ok = 1'b0;
            #1;
            checks++;
            if (hs !== 5'b10000 || mem_addr !== ia) begin
                errors++;
                $display("FAIL bp_hold%0d: handshakes=%b addr=%h expected 10000 addr=%h",
                         c, hs, mem_addr, ia);
            end
        end
        tick();
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b11000 || mem_addr !== ia) begin
            errors++;
            $display("FAIL bp_accept: handshakes=%b addr=%h expected 11000 addr=%h", hs, mem_addr, ia);
        end
        exp_q.push_back('{is_data: 1'b0, rdata: mem_model(ia)});
        tick();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = mem_model(ia);
        tick();
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b10100 || mem_addr !== da) begin
            errors++;
            $display("FAIL bp_next_data: handshakes=%b addr=%h expected 10100 addr=%h", hs, mem_addr, da);
        end
        exp_q.push_back('{is_data: 1'b1, rdata: mem_model(da)});
        tick();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = mem_model(da);
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        tick();
        data_req    = 1'b1;
        data_addr   = 32'h0000_0600;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b10100) begin
            errors++;
            $display("FAIL rmid_addr_phase: handshakes=%b expected 10100", hs);
        end
        tick();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        reset       = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hdead_beef;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++;
            $display("FAIL rmid_in_reset: handshakes=%b expected 00000", hs);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++;
            $display("FAIL rmid_late_resp: handshakes=%b expected 00000", hs);
        end
        tick();
        mem_data_ok = 1'b0;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        inst_addr   = 32'h1c00_0400;
        data_addr   = 32'h0000_0700;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b11000 || mem_addr !== 32'h1c00_0400) begin
            errors++;
            $display("FAIL rmid_tie: handshakes=%b addr=%h expected 11000 addr=1c000400", hs, mem_addr);
        end
        exp_q.push_back('{is_data: 1'b0, rdata: mem_model(32'h1c00_0400)});
        tick();
        clear_inputs();
        mem_data_ok = 1'b1;
        mem_rdata   = mem_model(32'h1c00_0400);
        tick();
        clear_inputs();
    endtask

    task automatic test_spurious();
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hbad0_0001;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++;
            $display("FAIL spur_idle: handshakes=%b expected 00000", hs);
        end
        tick();
        inst_req    = 1'b1;
        inst_addr   = 32'h1c00_0500;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b10000) begin
            errors++;
            $display("FAIL spur_with_req: handshakes=%b expected 10000", hs);
        end
        tick();
        mem_data_ok = 1'b0;
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if (hs !== 5'b11000 || mem_addr !== 32'h1c00_0500) begin
            errors++;
            $display("FAIL spur_accept: handshakes=%b addr=%h expected 11000 addr=1c000500", hs, mem_addr);
        end
        exp_q.push_back('{is_data: 1'b0, rdata: mem_model(32'h1c00_0500)});
        tick();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = mem_model(32'h1c00_0500);
        #1;
        checks++;
        if (hs !== 5'b00010) begin
            errors++;
            $display("FAIL spur_resp: handshakes=%b expected 00010", hs);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        reset      = 1'b1;
        inst_addr  = 32'h0;
        data_addr  = 32'h0;
        clear_inputs();
        test_reset();
        test_inst_only();
        test_store();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_spurious();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
